// File: rtl/uart_fifo2line_buffer_ring_if.sv
// Handshake bundle between the UART RX FIFO side and the line-buffer ring controller.
interface uart_fifo2line_buffer_ring_if #(
   parameter int CNT_W  = 14,
   parameter int COL_W  = 9,
   parameter int SEL_W  = 2,
   parameter int LINE_W = 10
);
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic              line_req;
   logic              lb_wr_en;
   logic [COL_W-1:0]  lb_wr_col;
   logic [SEL_W-1:0]  lb_wr_sel;
   logic [LINE_W-1:0] line_counter;
   logic              busy;
   logic              frame_done;
   logic              req_overrun;
   logic              timeout;

   modport master (
      input  fifo_count, fifo_empty, line_req,
      output fifo_rd_en, lb_wr_en, lb_wr_col, lb_wr_sel, line_counter,
             busy, frame_done, req_overrun, timeout
   );

   modport slave (
      output fifo_count, fifo_empty, line_req,
      input  fifo_rd_en, lb_wr_en, lb_wr_col, lb_wr_sel, line_counter,
             busy, frame_done, req_overrun, timeout
   );
endinterface

// File: rtl/uart_fifo2line_buffer_ring.sv
// Moves bytes from the UART RX FIFO into a ring of line buffers: preload, then one line per request.
// Optional stall watchdog is compiled in with `define LB_WATCHDOG_EN.
module uart_fifo2line_buffer_ring #(
   parameter int LINE_BYTES     = 512,
   parameter int NUM_LINES      = 512,
   parameter int PRELOAD_LINES  = 4,
   parameter int NUM_LB         = 4,
   parameter int CNT_W          = 14,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic clk,
   input logic reset,
   uart_fifo2line_buffer_ring_if.master bus
);
   localparam int COL_W  = $clog2(LINE_BYTES);
   localparam int LINE_W = $clog2(NUM_LINES + 1);
   localparam int SEL_W  = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;
   localparam int TGT_W  = $clog2(PRELOAD_LINES * LINE_BYTES + 1);

   localparam logic [CNT_W-1:0]  PRE_CNT   = CNT_W'(PRELOAD_LINES * LINE_BYTES);
   localparam logic [CNT_W-1:0]  LINE_CNT  = CNT_W'(LINE_BYTES);
   localparam logic [TGT_W-1:0]  PRE_TGT   = TGT_W'(PRELOAD_LINES * LINE_BYTES);
   localparam logic [TGT_W-1:0]  LINE_TGT  = TGT_W'(LINE_BYTES);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_BYTES - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_LB - 1);
   localparam logic [LINE_W-1:0] LINES_ALL = LINE_W'(NUM_LINES);

   typedef enum logic [2:0] {
      S_INIT_WAIT, S_PRELOAD, S_LINE_READ, S_DRAIN, S_MAIN_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [TGT_W-1:0]  issued_q, issued_d, target_q, target_d;
   logic              pending_q, pending_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
   logic              busy_q, busy_d, frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d, timeout_q, timeout_d;
   logic              consume, frame_end;

`ifdef LB_WATCHDOG_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            in_read;
`endif

   always_comb begin
      state_d      = state_q;
      issued_d     = issued_q;
      target_d     = target_q;
      pending_d    = pending_q;
      rd_en_d      = 1'b0;
      wr_en_d      = rd_en_q;
      col_d        = col_q;
      sel_d        = sel_q;
      line_cnt_d   = line_cnt_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      timeout_d    = 1'b0;
      consume      = 1'b0;
      frame_end    = 1'b0;

      // col/sel always show the slot of the next write, so a stall simply holds them
      if (wr_en_q) begin
         if (col_q == COL_LAST) begin
            col_d      = '0;
            sel_d      = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            line_cnt_d = line_cnt_q + LINE_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end

      case (state_q)
         S_INIT_WAIT: begin
            pending_d = 1'b0;
            if (bus.fifo_count >= PRE_CNT) begin
               state_d  = S_PRELOAD;
               target_d = PRE_TGT;
               issued_d = '0;
            end
         end
         S_PRELOAD, S_LINE_READ: begin
            if (!bus.fifo_empty && issued_q < target_q) begin
               rd_en_d  = 1'b1;
               issued_d = issued_q + TGT_W'(1);
            end else if (issued_q == target_q && !rd_en_q && !wr_en_q) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (line_cnt_q == LINES_ALL) begin
               frame_done_d = 1'b1;
               frame_end    = 1'b1;
               line_cnt_d   = '0;
               sel_d        = '0;
               state_d      = S_INIT_WAIT;
            end else begin
               state_d = S_MAIN_WAIT;
            end
         end
         S_MAIN_WAIT: begin
            if (pending_q && bus.fifo_count >= LINE_CNT) begin
               consume  = 1'b1;
               target_d = LINE_TGT;
               issued_d = '0;
               state_d  = S_LINE_READ;
            end
         end
         default: state_d = S_INIT_WAIT;
      endcase

      // A single pending slot: a request arriving while one is still unserved is flagged, not queued
      if (state_q inside {S_MAIN_WAIT, S_LINE_READ, S_DRAIN}) begin
         if (consume) begin
            pending_d = bus.line_req;
         end else if (bus.line_req) begin
            overrun_d = pending_q;
            pending_d = 1'b1;
         end
      end
      if (frame_end) pending_d = 1'b0;

`ifdef LB_WATCHDOG_EN
      in_read = (state_q == S_PRELOAD) || (state_q == S_LINE_READ);
      wd_d    = '0;
      if (in_read && issued_q < target_q && !rd_en_d) begin
         if (wd_q == WD_LAST) begin
            timeout_d  = 1'b1;
            state_d    = S_INIT_WAIT;
            line_cnt_d = '0;
            sel_d      = '0;
            col_d      = '0;
            pending_d  = 1'b0;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end
`endif

      busy_d = (state_d != S_INIT_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_INIT_WAIT;
         issued_q     <= '0;
         target_q     <= '0;
         pending_q    <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         col_q        <= '0;
         sel_q        <= '0;
         line_cnt_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef LB_WATCHDOG_EN
         wd_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         target_q     <= target_d;
         pending_q    <= pending_d;
         rd_en_q      <= rd_en_d;
         wr_en_q      <= wr_en_d;
         col_q        <= col_d;
         sel_q        <= sel_d;
         line_cnt_q   <= line_cnt_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
`ifdef LB_WATCHDOG_EN
         wd_q         <= wd_d;
`endif
      end
   end

   assign bus.fifo_rd_en   = rd_en_q;
   assign bus.lb_wr_en     = wr_en_q;
   assign bus.lb_wr_col    = col_q;
   assign bus.lb_wr_sel    = sel_q;
   assign bus.line_counter = line_cnt_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.req_overrun  = overrun_q;
   assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_uart_fifo2line_buffer_ring.sv
// Scoreboard bench for the FIFO-to-line-buffer controller on a small geometry:
// 16-byte lines, 6-line frame, 4-buffer ring, 4-line preload, 40-cycle watchdog.
`timescale 1ns/1ps
module tb_uart_fifo2line_buffer_ring;
   localparam int LINE_BYTES     = 16;
   localparam int NUM_LINES      = 6;
   localparam int PRELOAD_LINES  = 4;
   localparam int NUM_LB         = 4;
   localparam int CNT_W          = 14;
   localparam int TIMEOUT_CYCLES = 40;
   localparam int COL_W          = 4;
   localparam int LINE_W         = 3;
   localparam int SEL_W          = 2;

   typedef struct { int col; int sel; } wr_t;
   typedef struct { string name; int actual; int expected; } chk_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic line_req = 1'b0;
   logic force_empty = 1'b0;
   int   pushed = 0;
   int   popped = 0;
   int   rd_cnt = 0, wr_cnt = 0, frame_cnt = 0, overrun_cnt = 0, timeout_cnt = 0;
   bit   free_run = 1'b0, done = 1'b0, prev_rd = 1'b0;
   int   n_vec = 0, n_err = 0;
   wr_t  exp_wr_q[$];
   chk_t chk_q[$];

   uart_fifo2line_buffer_ring_if #(
      .CNT_W(CNT_W), .COL_W(COL_W), .SEL_W(SEL_W), .LINE_W(LINE_W)
   ) bus ();

   assign bus.fifo_count = CNT_W'(pushed - popped);
   assign bus.fifo_empty = (pushed == popped) || force_empty;
   assign bus.line_req   = line_req;

   uart_fifo2line_buffer_ring #(
      .LINE_BYTES(LINE_BYTES), .NUM_LINES(NUM_LINES), .PRELOAD_LINES(PRELOAD_LINES),
      .NUM_LB(NUM_LB), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic void compare(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic int outputs_word();
      logic [14:0] v;
      v = {bus.fifo_rd_en, bus.lb_wr_en, bus.lb_wr_col, bus.lb_wr_sel, bus.line_counter,
           bus.busy, bus.frame_done, bus.req_overrun, bus.timeout};
      return int'(v);
   endfunction

   // Monitor: FIFO model, write scoreboard, event counters and all comparisons live here
   always @(negedge clk) begin
      chk_t c;
      wr_t  w;
      if (bus.fifo_rd_en) begin
         compare("read_not_blind", int'(pushed > popped), 1);
         popped <= popped + 1;
         rd_cnt <= rd_cnt + 1;
      end
      if (bus.lb_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         compare("wr_follows_rd", int'(prev_rd), 1);
         if (!free_run) begin
            if (exp_wr_q.size() == 0) begin
               compare("wr_expected", exp_wr_q.size(), 1);
            end else begin
               w = exp_wr_q.pop_front();
               compare("wr_col", int'(bus.lb_wr_col), w.col);
               compare("wr_sel", int'(bus.lb_wr_sel), w.sel);
            end
         end
      end
      prev_rd <= bus.fifo_rd_en;
      if (bus.frame_done)  frame_cnt   <= frame_cnt + 1;
      if (bus.req_overrun) overrun_cnt <= overrun_cnt + 1;
      if (bus.timeout)     timeout_cnt <= timeout_cnt + 1;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         compare(c.name, c.actual, c.expected);
      end
      if (done) begin
         compare("wr_queue_drained", exp_wr_q.size(), 0);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      chk_q.push_back('{name, act, exp});
   endtask

   task automatic pulse_req();
      line_req = 1'b1;
      tick(1);
      line_req = 1'b0;
   endtask

   task automatic push_line(input int idx);
      for (int c = 0; c < LINE_BYTES; c++) exp_wr_q.push_back('{c, idx % NUM_LB});
   endtask

   task automatic wait_wr(input int n, input int budget, input string name);
      int k = 0;
      while (wr_cnt < n && k < budget) begin
         tick(1);
         k++;
      end
      check_output(name, wr_cnt, n);
   endtask

   task automatic apply_stimulus();
      int a;
      reset = 1'b1;
      tick(3);
      check_output("reset_outputs", outputs_word(), 0);
      reset = 1'b0;

      // one byte short of the preload threshold: nothing may be read
      pushed = 63;
      tick(10);
      check_output("no_read_below_preload", rd_cnt, 0);
      check_output("idle_not_busy", int'(bus.busy), 0);
      for (int l = 0; l < PRELOAD_LINES; l++) push_line(l);
      pushed = 64;
      wait_wr(64, 200, "preload_writes");
      tick(4);
      check_output("lc_after_preload", int'(bus.line_counter), 4);
      check_output("busy_main_wait", int'(bus.busy), 1);
      check_output("no_frame_done_yet", frame_cnt, 0);
      check_output("preload_reads", rd_cnt, 64);

      // request with one byte short of a line, then top up
      pushed += 15;
      pulse_req();
      tick(10);
      check_output("no_read_below_line", rd_cnt, 64);
      push_line(4);
      pushed += 1;
      wait_wr(80, 100, "line4_writes");
      tick(4);
      check_output("lc_after_line4", int'(bus.line_counter), 5);

      // stall the FIFO for 10 cycles mid-line
      push_line(5);
      pushed += 16;
      pulse_req();
      wait_wr(89, 100, "stall_point");
      force_empty = 1'b1;
      tick(1);
      a = rd_cnt;
      tick(9);
      force_empty = 1'b0;
      tick(1);
      check_output("stall_no_reads", rd_cnt, a);
      wait_wr(96, 100, "line5_writes");
      tick(6);
      check_output("frame1_done_pulses", frame_cnt, 1);
      check_output("lc_after_frame1", int'(bus.line_counter), 0);
      check_output("idle_after_frame1", int'(bus.busy), 0);
      check_output("sel_after_frame1", int'(bus.lb_wr_sel), 0);

      // second frame, two requests inside one line read -> one overrun, one extra line
      for (int l = 0; l < PRELOAD_LINES; l++) push_line(l);
      pushed += 64;
      wait_wr(160, 200, "frame2_preload_writes");
      tick(3);
      push_line(4);
      push_line(5);
      pushed += 32;
      pulse_req();
      wait_wr(162, 100, "frame2_line4_started");
      pulse_req();
      tick(2);
      pulse_req();
      wait_wr(192, 200, "frame2_all_writes");
      tick(6);
      check_output("overrun_pulses", overrun_cnt, 1);
      check_output("frame2_done_pulses", frame_cnt, 2);
      check_output("lc_after_frame2", int'(bus.line_counter), 0);
      check_output("idle_after_frame2", int'(bus.busy), 0);
      check_output("total_reads", rd_cnt, 192);

      // FIFO stuck empty mid-preload
      free_run = 1'b1;
      pushed += 70;
      wait_wr(212, 200, "stuck_point");
      force_empty = 1'b1;
      tick(TIMEOUT_CYCLES + 5);
`ifdef LB_WATCHDOG_EN
      check_output("timeout_pulses", timeout_cnt, 1);
      check_output("busy_after_timeout", int'(bus.busy), 0);
      check_output("lc_after_timeout", int'(bus.line_counter), 0);
`else
      check_output("timeout_pulses", timeout_cnt, 0);
      check_output("busy_while_stuck", int'(bus.busy), 1);
      check_output("lc_while_stuck", int'(bus.line_counter), 1);
`endif
      force_empty = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);
      check_output("reset_midline_outputs", outputs_word(), 0);
      reset = 1'b0;
      tick(2);
   endtask

   initial begin
      apply_stimulus();
      done = 1'b1;
      tick(5);
      $display("[TB] FAIL monitor_finish: got 0, expected 1");
      $fatal(1, "[TB] monitor did not end the run");
   end
endmodule

// File: doc/uart_fifo2line_buffer_ring.md
Name: uart_fifo2line_buffer_ring

Overview:
Parametrised successor controller between the UART RX FIFO and a ring of NUM_LB line buffers.
- Preloads PRELOAD_LINES lines at frame start.
- Afterwards fetches one line per latched line request.
- Produces per-byte write strobes, column, buffer index and line count.
- Gates every read on fifo_empty, so the FIFO is never read blind.

Parameters:
LINE_BYTES, 512, bytes per line; COL_W = clog2(LINE_BYTES)
NUM_LINES, 512, lines per frame; LINE_W = clog2(NUM_LINES+1)
PRELOAD_LINES, 4, lines fetched before the first request is served; 1..min(NUM_LB,NUM_LINES)
NUM_LB, 4, line buffers in the ring; SEL_W = max(1,clog2(NUM_LB))
CNT_W, 14, width of the FIFO occupancy input
TIMEOUT_CYCLES, 65535, stall limit; used only with the optional feature

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fifo_count  in  CNT_W  RX FIFO occupancy in bytes
fifo_empty  in  1  RX FIFO empty
fifo_rd_en  out  1  FIFO read strobe; data valid the following cycle
line_req  in  1  request for next line (pulse or level; each high cycle counts)
lb_wr_en  out  1  line-buffer write, aligned with FIFO read data
lb_wr_col  out  COL_W  byte column of current write
lb_wr_sel  out  SEL_W  target buffer = line index mod NUM_LB
line_counter  out  LINE_W  lines completely written this frame
busy  out  1  high outside S_INIT_WAIT
frame_done  out  1  one-cycle pulse after line NUM_LINES-1 is written
req_overrun  out  1  one-cycle pulse: line_req while a request is already pending
timeout  out  1  one-cycle pulse on watchdog abort; constant 0 without the feature

Behaviour:
- Reset: state S_INIT_WAIT; pending, all counters and all outputs = 0.
- State S_INIT_WAIT:
  - fifo_count >= PRELOAD_LINES*LINE_BYTES -> S_PRELOAD with target = PRELOAD_LINES*LINE_BYTES bytes.
  - line_req ignored; pending held 0.
- State S_PRELOAD / S_LINE_READ (read states):
  - fifo_rd_en = !fifo_empty && issued < target.
  - issued increments on each fifo_rd_en.
  - lb_wr_en = fifo_rd_en delayed one cycle (registered).
  - lb_wr_col and lb_wr_sel are registered with lb_wr_en.
  - col wraps LINE_BYTES-1 -> 0; sel increments mod NUM_LB on wrap.
- Line completion: lb_wr_en with col == LINE_BYTES-1 -> line_counter+1 on the next edge.
- Read-state exit: issued == target and the last write done -> S_DRAIN (1 cycle).
- State S_DRAIN:
  - line_counter == NUM_LINES -> frame_done pulse, line_counter = 0, sel = 0, pending = 0, S_INIT_WAIT.
  - else -> S_MAIN_WAIT.
- State S_MAIN_WAIT:
  - pending && fifo_count >= LINE_BYTES -> clear pending, target = LINE_BYTES, S_LINE_READ.
  - Reaching S_MAIN_WAIT with line_counter < NUM_LINES never deadlocks; it waits for a request.
- line_req handling (S_MAIN_WAIT, S_LINE_READ, S_DRAIN):
  - Sets pending.
  - If pending is already 1 and not consumed that cycle -> req_overrun pulse; pending stays 1 (requests do not queue).
  - Consume and new line_req in the same cycle -> pending = 1, no overrun.
- Stall: fifo_empty mid-line pauses reads with no byte lost, duplicated or written out of order; col/sel hold.
- Frame boundary: NUM_LINES not a multiple of NUM_LB is legal; sel resets to 0 each frame.
- Reset mid-line: returns to S_INIT_WAIT immediately and abandons partial data. The FIFO is not flushed by this block.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
Macro: LB_WATCHDOG_EN.
- Enabled:
  - In a read state, a cycle counter counts consecutive cycles with issued < target and fifo_rd_en low, and clears on any read.
  - At TIMEOUT_CYCLES: timeout pulse, line_counter = 0, sel = 0, col = 0, pending = 0, state S_INIT_WAIT.
  - Any read already issued still completes its lb_wr_en the next cycle.
- Disabled: no counter logic; timeout tied 0; stall is indefinite.

Test Plan:
- Defaults; fifo_count ramps to 2047 then 2048 -> no read at 2047; at 2048, 2048 fifo_rd_en pulses, lb_wr_sel 0..3, line_counter = 4, S_MAIN_WAIT, frame_done = 0.
- After preload, line_req pulse with fifo_count = 511, then 512 -> no read until 512; then 512 writes to sel 0 (line 4), line_counter = 5.
- fifo_empty forced high for 10 cycles at col 100 -> fifo_rd_en low 10 cycles, col resumes at 101, total writes still 512, data order intact.
- Two line_req pulses during S_LINE_READ -> req_overrun pulses once, exactly one extra line fetched afterwards.
- NUM_LINES = 6, NUM_LB = 4, PRELOAD_LINES = 4, 2 requests -> line_counter reaches 6, frame_done one cycle, line_counter = 0, S_INIT_WAIT; next frame starts at sel 0.
- With LB_WATCHDOG_EN, TIMEOUT_CYCLES = 100, fifo_empty stuck mid-preload -> timeout pulse at stall cycle 100, line_counter = 0, busy = 0. Reset asserted mid-line -> all outputs 0 the next cycle.
